column_field_gen: RTL and testbench

COLUMN_FIELD_GEN -- requirements
Module: column_field_gen

---
 rtl/column_field_gen.sv | 109 ++++++++++
 tb/tb_column_field_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/column_field_gen.sv
// Scrolling pipe-column field. Each column moves left by (speed + 1) pixels
// per game tick. A column that would pass x = 0 respawns at the right edge
// and gets a fresh gap centre from a shared Galois LFSR. Respawns drive a
// one-tick pass pulse and a saturating score.
module column_field_gen #(
    parameter int          NUM_COLS      = 2,
    parameter int          COORD_W       = 11,
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          PADDING       = 160,
    parameter int          PIPE_WIDTH    = 40,
    parameter int          SPACING       = 320,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          SCORE_W       = 8
) (
    input  logic                        gameClk,
    input  logic                        reset,
    input  logic                        finished,
    input  logic [1:0]                  speed,
    output logic [NUM_COLS*COORD_W-1:0] colX,
    output logic [NUM_COLS*COORD_W-1:0] colY,
    output logic                        passColumn,
    output logic [SCORE_W-1:0]          score
);

    localparam int unsigned X_RESPAWN = SCREEN_WIDTH + 2*PIPE_WIDTH - 1;
    localparam int unsigned Y_MIN     = PADDING / 2;
    localparam int unsigned Y_SPAN    = SCREEN_HEIGHT - PADDING;
    localparam int unsigned X_START   = SCREEN_WIDTH/2 + 2*PIPE_WIDTH - 1;
    localparam int          SUM_W     = SCORE_W + 4;

    // Gap centre for column i: rotate the LFSR left by 3*i so columns that
    // respawn in the same tick still get different heights.
    function automatic logic [COORD_W-1:0] gap_y(input logic [15:0] v,
                                                 input int unsigned i);
        logic [15:0] r;
        int unsigned sh;
        sh = (3 * i) % 16;
        r  = (v << sh) | (v >> ((16 - sh) % 16));
        gap_y = COORD_W'(Y_MIN + (32'(r) % Y_SPAN));
    endfunction

    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [COORD_W-1:0] x_q    [NUM_COLS];
    logic [COORD_W-1:0] y_q    [NUM_COLS];
    logic [COORD_W-1:0] x_next [NUM_COLS];
    logic [COORD_W-1:0] y_next [NUM_COLS];
    logic [COORD_W-1:0] step;
    logic [3:0]         hits;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    // Next-state for every column, the LFSR and the saturating score.
    always_comb begin
        step      = COORD_W'(speed) + COORD_W'(1);
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        hits      = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (x_q[i] < step) begin
                x_next[i] = COORD_W'(X_RESPAWN);
                y_next[i] = gap_y(lfsr, i);
                hits      = hits + 4'd1;
            end else begin
                x_next[i] = x_q[i] - step;
                y_next[i] = y_q[i];
            end
        end
        score_sum = SUM_W'(score) + SUM_W'(hits);
        if (|score_sum[SUM_W-1:SCORE_W])
            score_next = '1;
        else
            score_next = score_sum[SCORE_W-1:0];
    end

    // Field state: advances each tick unless frozen by finished.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                x_q[i] <= COORD_W'(X_START + i * SPACING);
                y_q[i] <= gap_y(LFSR_SEED, i);
            end
            passColumn <= 1'b0;
            score      <= '0;
        end else if (!finished) begin
            lfsr <= lfsr_next;
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                x_q[i] <= x_next[i];
                y_q[i] <= y_next[i];
            end
            passColumn <= (hits != 4'd0);
            score      <= score_next;
        end else begin
            passColumn <= 1'b0;
        end
    end

    // Pack per-column coordinates onto the flat output buses.
    always_comb begin
        colX = '0;
        colY = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            colX[i*COORD_W +: COORD_W] = x_q[i];
            colY[i*COORD_W +: COORD_W] = y_q[i];
        end
    end

endmodule

// File: tb/tb_column_field_gen.sv
// Directed bench for column_field_gen: default field, coincident respawn
// (SPACING 0) and score saturation (SCORE_W 2), one instance each.
module tb_column_field_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        gameClk;
    logic        reset;
    logic        fin_a, fin_b, fin_c;
    logic [1:0]  spd_a, spd_b, spd_c;
    logic [21:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic        pass_a, pass_b, pass_c;
    logic [7:0]  score_a, score_b;
    logic [1:0]  score_c;

    int total = 0;
    int bad   = 0;

    column_field_gen dut_a (
        .gameClk(gameClk), .reset(reset), .finished(fin_a), .speed(spd_a),
        .colX(x_a), .colY(y_a), .passColumn(pass_a), .score(score_a)
    );

    column_field_gen #(.SPACING(0)) dut_b (
        .gameClk(gameClk), .reset(reset), .finished(fin_b), .speed(spd_b),
        .colX(x_b), .colY(y_b), .passColumn(pass_b), .score(score_b)
    );

    column_field_gen #(.SCORE_W(2)) dut_c (
        .gameClk(gameClk), .reset(reset), .finished(fin_c), .speed(spd_c),
        .colX(x_c), .colY(y_c), .passColumn(pass_c), .score(score_c)
    );

    initial begin
        gameClk = 1'b0;
        forever #5 gameClk = ~gameClk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic int col(input logic [21:0] v, input int i);
        return int'(v[i*11 +: 11]);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < n; k++)
            r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
        return r;
    endfunction

    function automatic int model_gap(input logic [15:0] v, input int i);
        logic [15:0] r;
        r = v;
        for (int k = 0; k < 3*i; k++)
            r = {r[14:0], r[15]};
        return 80 + int'(r) % 320;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gameClk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge gameClk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        fin_a = 1'b0; fin_b = 1'b1; fin_c = 1'b1;
        spd_a = 2'd0; spd_b = 2'd3; spd_c = 2'd3;

        // default field, speed 0
        pulse_reset();
        check("rst_x0", col(x_a, 0), 399);
        check("rst_x1", col(x_a, 1), 719);
        check("rst_y0", col(y_a, 0), 177);
        check("rst_y1", col(y_a, 1), 221);
        check("rst_pass", int'(pass_a), 0);
        check("rst_score", int'(score_a), 0);

        tick(399);
        check("a399_x0", col(x_a, 0), 0);
        check("a399_x1", col(x_a, 1), 320);
        check("a399_y0", col(y_a, 0), 177);
        check("a399_pass", int'(pass_a), 0);

        tick(1);
        check("a400_x0", col(x_a, 0), 719);
        check("a400_y0", col(y_a, 0), model_gap(lfsr_adv(SEED, 399), 0));
        check("a400_x1", col(x_a, 1), 319);
        check("a400_y1", col(y_a, 1), 221);
        check("a400_pass", int'(pass_a), 1);
        check("a400_score", int'(score_a), 1);

        tick(1);
        check("a401_x0", col(x_a, 0), 718);
        check("a401_pass", int'(pass_a), 0);
        check("a401_score", int'(score_a), 1);

        // speed 3 from here on
        spd_a = 2'd3;
        tick(79);
        check("s79_x1", col(x_a, 1), 2);
        tick(1);
        check("s80_x1", col(x_a, 1), 719);
        check("s80_x0", col(x_a, 0), 398);
        check("s80_y1", col(y_a, 1), model_gap(lfsr_adv(SEED, 480), 1));
        check("s80_pass", int'(pass_a), 1);
        check("s80_score", int'(score_a), 2);
        tick(99);
        check("s179_x0", col(x_a, 0), 2);
        check("s179_x1", col(x_a, 1), 323);
        tick(1);
        check("s180_x0", col(x_a, 0), 719);
        check("s180_x1", col(x_a, 1), 319);
        check("s180_y0", col(y_a, 0), model_gap(lfsr_adv(SEED, 580), 0));
        check("s180_pass", int'(pass_a), 1);
        check("s180_score", int'(score_a), 3);

        // freeze for 50 ticks
        fin_a = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick(1);
            check("frz_x0", col(x_a, 0), 719);
            check("frz_x1", col(x_a, 1), 319);
            check("frz_pass", int'(pass_a), 0);
            check("frz_score", int'(score_a), 3);
        end
        check("frz_y0", col(y_a, 0), model_gap(lfsr_adv(SEED, 580), 0));
        check("frz_y1", col(y_a, 1), model_gap(lfsr_adv(SEED, 480), 1));

        fin_a = 1'b0;
        tick(1);
        check("rel_x0", col(x_a, 0), 715);
        check("rel_x1", col(x_a, 1), 315);
        check("rel_pass", int'(pass_a), 0);
        tick(78);
        check("rel78_x1", col(x_a, 1), 3);
        tick(1);
        check("rel79_x1", col(x_a, 1), 719);
        check("rel79_x0", col(x_a, 0), 399);
        check("rel79_y1", col(y_a, 1), model_gap(lfsr_adv(SEED, 660), 1));
        check("rel79_pass", int'(pass_a), 1);
        check("rel79_score", int'(score_a), 4);

        // coincident respawn with SPACING 0
        fin_a = 1'b1;
        fin_b = 1'b0;
        pulse_reset();
        check("b_rst_x0", col(x_b, 0), 399);
        check("b_rst_x1", col(x_b, 1), 399);
        check("b_rst_score", int'(score_b), 0);
        tick(99);
        check("b99_x0", col(x_b, 0), 3);
        check("b99_x1", col(x_b, 1), 3);
        tick(1);
        check("b100_x0", col(x_b, 0), 719);
        check("b100_x1", col(x_b, 1), 719);
        check("b100_y0", col(y_b, 0), model_gap(lfsr_adv(SEED, 99), 0));
        check("b100_y1", col(y_b, 1), model_gap(lfsr_adv(SEED, 99), 1));
        check("b100_pass", int'(pass_b), 1);
        check("b100_score", int'(score_b), 2);

        // saturation with SCORE_W 2, then asynchronous reset
        fin_b = 1'b1;
        fin_c = 1'b0;
        pulse_reset();
        tick(100);
        check("c1_pass", int'(pass_c), 1);
        check("c1_score", int'(score_c), 1);
        tick(80);
        check("c2_score", int'(score_c), 2);
        tick(100);
        check("c3_score", int'(score_c), 3);
        tick(80);
        check("c4_x1", col(x_c, 1), 719);
        check("c4_pass", int'(pass_c), 1);
        check("c4_score", int'(score_c), 3);

        #2;
        reset = 1'b1;
        #1;
        check("c_ar_x0", col(x_c, 0), 399);
        check("c_ar_x1", col(x_c, 1), 719);
        check("c_ar_y0", col(y_c, 0), 177);
        check("c_ar_y1", col(y_c, 1), 221);
        check("c_ar_pass", int'(pass_c), 0);
        check("c_ar_score", int'(score_c), 0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
